fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 16 +
 rtl/fetch_buffer.sv | 64 ++++++
 rtl/fetch_unit.sv | 87 ++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared constants and slot type for the instruction fetch unit
package fetch_unit_pkg;

    localparam int              XLEN             = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_slot_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - circular instruction buffer with flush, head is zero when empty
module fetch_buffer
    import fetch_unit_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push_i,
    input  fetch_slot_t                  push_slot_i,
    input  logic                         pop_i,
    input  logic                         flush_i,
    output fetch_slot_t                  head_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_slot_t      mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        do_pop   = pop_i & (count_q != '0);
        do_push  = push_i & ((count_q != CNT_W'(DEPTH)) | do_pop);
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_slot_i;
    end

    assign head_o  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - credit-based instruction fetch with redirect flush and stale-response dropping
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int              BUF_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_instr,
    output logic [XLEN-1:0] if_pc
);
    localparam int             CNT_W   = $clog2(BUF_DEPTH + 1);
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(BUF_DEPTH);

    logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d, drop_cnt_q, drop_cnt_d;
    logic [CNT_W-1:0] buf_count;
    logic             fire, push, pop, dropping;
    fetch_slot_t      push_slot, head_slot;

    // Counters read zero while in reset, so rst_n gates the request to keep it low there.
    assign imem_req_valid = rst_n & (({1'b0, outstanding_q} + {1'b0, buf_count}) < DEPTH_C);
    assign imem_req_addr  = fetch_pc_q;
    assign if_valid       = (buf_count != '0) & ~redirect_valid;
    assign if_instr       = head_slot.instr;
    assign if_pc          = head_slot.pc;
    assign push_slot      = '{instr: imem_rsp_data, pc: rsp_pc_q};

    always_comb begin
        fire          = imem_req_valid & imem_req_ready;
        pop           = if_valid & if_ready;
        dropping      = (drop_cnt_q != '0);
        push          = imem_rsp_valid & ~redirect_valid & ~dropping;
        outstanding_d = outstanding_q + CNT_W'(fire) - CNT_W'(imem_rsp_valid);
        fetch_pc_d    = fetch_pc_q;
        rsp_pc_d      = rsp_pc_q;
        drop_cnt_d    = drop_cnt_q;
        if (redirect_valid) begin
            // Everything still in flight after this edge belongs to the old stream.
            fetch_pc_d = word_align(redirect_pc);
            rsp_pc_d   = word_align(redirect_pc);
            drop_cnt_d = outstanding_d;
        end else begin
            if (fire)                      fetch_pc_d = fetch_pc_q + 32'd4;
            if (push)                      rsp_pc_d   = rsp_pc_q + 32'd4;
            if (imem_rsp_valid && dropping) drop_cnt_d = drop_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    fetch_buffer #(
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push),
        .push_slot_i (push_slot),
        .pop_i       (pop),
        .flush_i     (redirect_valid),
        .head_o      (head_slot),
        .count_o     (buf_count)
    );

endmodule
